// File: rtl/change_dispenser.sv
// change_dispenser: greedy 10/5/2/1 coin payout with valid/ack handshake and ack timeout.
// Optional COIN_TALLY_EN adds a coinCount output tallying acked coins.
module change_dispenser #(
  parameter int WIDTH = 5,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] changeAmount,
  input  logic             coinAck,
  output logic             coinValid,
  output logic [3:0]       coinValue,
  output logic [WIDTH-1:0] remaining,
  output logic             busy,
  output logic             done,
`ifdef COIN_TALLY_EN
  output logic [WIDTH-1:0] coinCount,
`endif
  output logic             fault
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, SELECT, OFFER, DONE} state_t;
  state_t state;
  logic [TW-1:0] timer;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      coinValid <= 1'b0;
      coinValue <= 4'd0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      timer     <= '0;
`ifdef COIN_TALLY_EN
      coinCount <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            remaining <= changeAmount;
            fault     <= 1'b0;
            busy      <= 1'b1;
            state     <= SELECT;
`ifdef COIN_TALLY_EN
            coinCount <= '0;
`endif
          end
        end
        SELECT: begin
          if (remaining == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            coinValue <= remaining >= WIDTH'(10) ? 4'd10 :
                         remaining >= WIDTH'(5)  ? 4'd5  :
                         remaining >= WIDTH'(2)  ? 4'd2  : 4'd1;
            coinValid <= 1'b1;
            timer     <= '0;
            state     <= OFFER;
          end
        end
        OFFER: begin
          // An ack in the expiry cycle wins over the timeout.
          if (coinAck) begin
            remaining <= remaining - WIDTH'(coinValue);
            coinValid <= 1'b0;
            coinValue <= 4'd0;
            state     <= SELECT;
`ifdef COIN_TALLY_EN
            coinCount <= coinCount + 1'b1;
`endif
          end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
            coinValid <= 1'b0;
            coinValue <= 4'd0;
            fault     <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed + randomized payouts checked against a division-based coin model.
module tb_change_dispenser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [4:0] changeAmount = '0;
  logic coinAck = 1'b0;
  logic coinValid, busy, done, fault;
  logic [3:0] coinValue;
  logic [4:0] remaining;
`ifdef COIN_TALLY_EN
  logic [4:0] coinCount;
`endif
  int checks = 0;
  int errors = 0;

  change_dispenser #(.WIDTH(5), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .changeAmount(changeAmount),
    .coinAck(coinAck), .coinValid(coinValid), .coinValue(coinValue),
    .remaining(remaining), .busy(busy), .done(done),
`ifdef COIN_TALLY_EN
    .coinCount(coinCount),
`endif
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: coin multiset from integer division, paid largest first.
  task automatic pay(input int amt, input int dmin, input int dmax, input bit spur);
    int q[$];
    int r, rem, d;
    r = amt;
    repeat (r / 10) q.push_back(10);
    r = r % 10;
    if (r >= 5) q.push_back(5);
    r = r % 5;
    repeat (r / 2) q.push_back(2);
    if (r % 2 == 1) q.push_back(1);
    changeAmount = 5'(amt);
    start = 1'b1;
    tick();
    start = 1'b0;
    changeAmount = 5'($urandom);
    check("busy_after_start", busy, 1);
    check("fault_cleared", fault, 0);
    check("rem_latched", remaining, amt);
    check("no_valid_in_select", coinValid, 0);
    rem = amt;
    foreach (q[i]) begin
      tick();
      coinAck = 1'b0;
      check("coin_valid", coinValid, 1);
      check("coin_value", coinValue, q[i]);
      d = $urandom_range(dmax, dmin);
      repeat (d) begin
        if (spur) begin
          start = 1'b1;
          changeAmount = 5'($urandom);
        end
        tick();
        start = 1'b0;
        check("hold_valid", coinValid, 1);
        check("hold_value", coinValue, q[i]);
        check("hold_rem", remaining, rem);
      end
      coinAck = 1'b1;
      tick();
      coinAck = 1'b0;
      rem -= q[i];
      check("gap_valid", coinValid, 0);
      check("gap_value", coinValue, 0);
      check("rem_after_ack", remaining, rem);
      if (spur) coinAck = 1'b1;
    end
    tick();
    coinAck = 1'b0;
    check("done_pulse", done, 1);
    check("valid_at_done", coinValid, 0);
    check("busy_at_done", busy, 1);
    check("rem_at_done", remaining, 0);
    check("fault_at_done", fault, 0);
`ifdef COIN_TALLY_EN
    check("coin_count", coinCount, q.size());
`endif
    tick();
    check("done_cleared", done, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    #1;
    check("rst_valid", coinValid, 0);
    check("rst_value", coinValue, 0);
    check("rst_rem", remaining, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    pay(18, 1, 1, 0);
    pay(0, 0, 0, 0);
    pay(7, 3, 3, 0);
    pay(31, 0, 2, 1);
    pay(9, 15, 15, 0);
    // Timeout: ack never arrives.
    changeAmount = 5'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("to_offer_valid", coinValid, 1);
    check("to_offer_value", coinValue, 5);
    repeat (15) tick();
    check("to_last_cycle_valid", coinValid, 1);
    check("to_last_cycle_fault", fault, 0);
    tick();
    check("to_valid", coinValid, 0);
    check("to_value", coinValue, 0);
    check("to_fault", fault, 1);
    check("to_rem", remaining, 9);
    check("to_busy", busy, 0);
    check("to_done", done, 0);
`ifdef COIN_TALLY_EN
    check("to_count", coinCount, 0);
`endif
    tick();
    check("to_fault_sticky", fault, 1);
    check("to_no_done", done, 0);
    pay(1, 0, 0, 0);
    // Async reset during the second coin of 20.
    changeAmount = 5'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    coinAck = 1'b1;
    tick();
    coinAck = 1'b0;
    tick();
    check("rst2_second_offer", coinValid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", coinValid, 0);
    check("arst_value", coinValue, 0);
    check("arst_rem", remaining, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_fault", fault, 0);
    tick();
    check("arst_no_done", done, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);
    pay(5, 0, 2, 0);
    for (int i = 0; i < 25; i++) pay($urandom_range(31, 0), 0, 3, 1'($urandom_range(1, 0)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Pays out change after a purchase. Latches a 5-bit change amount (money entered minus price) on a start pulse, then emits coins one at a time to the coin ejector using a greedy largest-first algorithm over denominations 10/5/2/1. Each coin uses a valid/ack handshake. The block raises done when the balance reaches zero and fault if the ejector stops acknowledging.

Parameters:
WIDTH, 5, width of change amount and remaining balance (max change 31)
ACK_TIMEOUT, 255, cycles in OFFER without coinAck before fault; counter sized by $clog2(ACK_TIMEOUT+1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE
changeAmount  input  WIDTH  change to pay; latched when start is accepted
coinAck  input  1  ejector accepted the offered coin
coinValid  output  1  coin offer pending
coinValue  output  4  denomination offered: 10, 5, 2 or 1; 0 when coinValid=0
remaining  output  WIDTH  balance not yet paid
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when payout completes
fault  output  1  sticky ejector-timeout flag

Behaviour:
- One clock, clk. Reset is asynchronous, active-low, on rst_n. All outputs are registered.
- Reset: state=IDLE, coinValid=0, coinValue=0, remaining=0, busy=0, done=0, fault=0, timeout counter=0.
- Reset asserted mid-payout aborts the payout immediately. It does not complete the current coin and raises no done pulse.
- States:
  - IDLE: on start=1, remaining<=changeAmount, fault<=0, go to SELECT. Without start, stay in IDLE.
  - SELECT: if remaining==0, go to DONE. Otherwise coinValue<=largest denomination ≤ remaining (≥10→10, ≥5→5, ≥2→2, else 1), coinValid<=1, timer<=0, go to OFFER.
  - OFFER: hold coinValid and coinValue stable.
    - On coinAck=1: remaining<=remaining−coinValue, coinValid<=0, coinValue<=0, go to SELECT.
    - Otherwise timer increments. When timer reaches ACK_TIMEOUT−1 with no ack: coinValid<=0, fault<=1, go to IDLE. remaining keeps the unpaid balance for diagnostics.
  - DONE: done<=1 for exactly one cycle, then IDLE.
- Latency:
  - coinValid rises 2 cycles after the cycle start is sampled.
  - At least one cycle with coinValid low separates consecutive coins.
  - An ack in the first OFFER cycle is legal.
- Zero change: start with changeAmount=0 gives done 2 cycles after start, and coinValid never rises.
- Simultaneous events:
  - start while busy is ignored.
  - coinAck outside OFFER is ignored.
  - coinAck in the same cycle the timeout expires counts as an ack, with no fault.
- Arithmetic: the subtraction never underflows because the selected coin is always ≤ remaining. Widths are WIDTH bits with no wrap.
- fault stays high until the next accepted start or reset.

Optional Feature:
COIN_TALLY_EN
- Defined: adds output coinCount (WIDTH bits). It clears to 0 on reset and on an accepted start, and increments on each acked coin. It holds its value after done or fault until the next start.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- changeAmount=18, start, ack 1 cycle after each coinValid → coins 10,5,2,1 in order; remaining 18→8→3→1→0; done pulse once; fault=0; coinCount=4 with COIN_TALLY_EN.
- changeAmount=0, start → done 2 cycles later, coinValid never high, busy high for 2 cycles.
- changeAmount=7, coinAck delayed 3 cycles per coin → offers 5 then 2; coinValue stable throughout each offer; remaining 7→2→0.
- ACK_TIMEOUT=16, changeAmount=9, coinAck held low → after 16 OFFER cycles coinValid=0, fault=1, remaining=9, no done; a new start with changeAmount=1 clears fault and pays 1.
- changeAmount=31, pulse start again during payout → second start ignored; coins 10,10,10,1 only.
- rst_n low during second coin of changeAmount=20 → all outputs 0 asynchronously; after release, IDLE, and start with 5 pays one coin of 5.
